// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker: shared tick prescaler, per-channel OFF/ON/BLINK/BURST.
// Optional MULTI_LED_SYNC_EN adds sync_start to realign all running channels.
module multi_led_blinker #(
  parameter  int NCH      = 4,
  parameter  int PRESCALE = 1200000,
  parameter  int CNT_W    = 8,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PS_W     = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_count,
`ifdef MULTI_LED_SYNC_EN
  input  logic             sync_start,
`endif
  output logic [NCH-1:0]   led,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_e;

  mode_e            mode_q [NCH];
  logic [CNT_W-1:0] half_q [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] hc_q   [NCH];
  logic [CNT_W-1:0] pc_q   [NCH];
  logic [NCH-1:0]   led_q;
  logic [NCH-1:0]   busy_q;
  logic [NCH-1:0]   done_q;
  logic [PS_W-1:0]  pre_q;
  logic             ready_q;

  logic tick;
  logic accept;
  mode_e mode_d;

  assign tick   = (pre_q == PS_W'(PRESCALE - 1));
  assign accept = cfg_valid && ready_q;
  assign mode_d = mode_e'(cfg_mode);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pre_q   <= '0;
      ready_q <= 1'b1;
      led_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i] <= M_OFF;
        half_q[i] <= '0;
        cnt_q[i]  <= '0;
        hc_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      ready_q <= ~accept;
      done_q  <= '0;
      pre_q   <= tick ? '0 : pre_q + PS_W'(1);
`ifdef MULTI_LED_SYNC_EN
      if (sync_start) pre_q <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        if (accept && cfg_ch == CH_W'(i)) begin
          mode_q[i] <= mode_d;
          half_q[i] <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
          cnt_q[i]  <= cfg_count;
          hc_q[i]   <= '0;
          pc_q[i]   <= '0;
          unique case (mode_d)
            M_OFF: begin
              led_q[i]  <= 1'b0;
              busy_q[i] <= 1'b0;
            end
            M_ON: begin
              led_q[i]  <= 1'b1;
              busy_q[i] <= 1'b0;
            end
            M_BLINK: begin
              led_q[i]  <= 1'b1;
              busy_q[i] <= 1'b1;
            end
            M_BURST: begin
              // zero-length burst finishes immediately
              if (cfg_count == '0) begin
                mode_q[i] <= M_OFF;
                led_q[i]  <= 1'b0;
                busy_q[i] <= 1'b0;
                done_q[i] <= 1'b1;
              end else begin
                led_q[i]  <= 1'b1;
                busy_q[i] <= 1'b1;
              end
            end
          endcase
        end
`ifdef MULTI_LED_SYNC_EN
        else if (sync_start && busy_q[i]) begin
          led_q[i] <= 1'b1;
          hc_q[i]  <= '0;
        end
`endif
        else if (tick && busy_q[i]) begin
          if (hc_q[i] == half_q[i] - CNT_W'(1)) begin
            hc_q[i] <= '0;
            if (mode_q[i] == M_BURST && !led_q[i]) begin
              if (pc_q[i] + CNT_W'(1) == cnt_q[i]) begin
                mode_q[i] <= M_OFF;
                busy_q[i] <= 1'b0;
                done_q[i] <= 1'b1;
              end else begin
                pc_q[i]  <= pc_q[i] + CNT_W'(1);
                led_q[i] <= 1'b1;
              end
            end else begin
              led_q[i] <= ~led_q[i];
            end
          end else begin
            hc_q[i] <= hc_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign cfg_ready = ready_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_multi_led_blinker.sv
// Bench for multi_led_blinker: tick-count reference model, directed + random writes.
// NCH=5 leaves cfg_ch codes 5..7 unmapped.
module tb_multi_led_blinker;
  localparam int NCH = 5;
  localparam int P   = 4;
  localparam int CW  = 8;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [CW-1:0]  cfg_half = '0;
  logic [CW-1:0]  cfg_count = '0;
`ifdef MULTI_LED_SYNC_EN
  logic           sync_start = 1'b0;
`endif
  logic [NCH-1:0] led, busy, done;

  always #5 clk = ~clk;

  multi_led_blinker #(
    .NCH(NCH), .PRESCALE(P), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_half(cfg_half),
    .cfg_count(cfg_count),
`ifdef MULTI_LED_SYNC_EN
    .sync_start(sync_start),
`endif
    .led(led),
    .busy(busy),
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Model: a channel's output is a function of ticks elapsed since its write.
  int m_mode [NCH];
  int m_half [NCH];
  int m_cnt  [NCH];
  int m_n    [NCH];
  bit m_done [NCH];
  bit m_ready = 1'b1;
  int m_cyc = 0;

  function automatic bit m_led(int i);
    if (m_mode[i] == 0) return 1'b0;
    if (m_mode[i] == 1) return 1'b1;
    return ((m_n[i] / m_half[i]) % 2) == 0;
  endfunction

  function automatic logic [3*NCH:0] m_vec();
    logic [NCH-1:0] l, b, d;
    for (int i = 0; i < NCH; i++) begin
      l[i] = m_led(i);
      b[i] = m_mode[i] >= 2;
      d[i] = m_done[i];
    end
    return {l, b, d, m_ready};
  endfunction

  task automatic step();
    bit tick, acc, syn;
    syn = 1'b0;
`ifdef MULTI_LED_SYNC_EN
    syn = sync_start;
`endif
    if (!nreset) begin
      m_cyc = 0;
      m_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_half[i] = 1; m_cnt[i] = 0;
        m_n[i] = 0; m_done[i] = 1'b0;
      end
    end else begin
      tick = (m_cyc % P) == P - 1;
      acc = cfg_valid && m_ready;
      m_ready = !acc;
      m_cyc = syn ? 0 : m_cyc + 1;
      for (int i = 0; i < NCH; i++) begin
        m_done[i] = 1'b0;
        if (acc && int'(cfg_ch) == i) begin
          m_half[i] = (cfg_half == 0) ? 1 : int'(cfg_half);
          m_cnt[i] = int'(cfg_count);
          m_n[i] = 0;
          m_mode[i] = int'(cfg_mode);
          if (cfg_mode == 3 && cfg_count == 0) begin
            m_mode[i] = 0;
            m_done[i] = 1'b1;
          end
        end else if (syn && m_mode[i] >= 2) begin
          m_n[i] = 2 * m_half[i] * (m_n[i] / (2 * m_half[i]));
        end else if (tick && m_mode[i] >= 2) begin
          m_n[i]++;
          if (m_mode[i] == 3 && m_n[i] == 2 * m_half[i] * m_cnt[i]) begin
            m_mode[i] = 0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(int ch, int mode, int half, int count);
    bit a;
    cfg_ch = CHW'(ch);
    cfg_mode = 2'(mode);
    cfg_half = CW'(half);
    cfg_count = CW'(count);
    cfg_valid = 1'b1;
    a = 1'b0;
    for (int k = 0; k < 4 && !a; k++) begin
      a = m_ready;
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({led, busy, done} !== '0 || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset: got %h/%b required 0/1",
                 {led, busy, done}, cfg_ready);
      end
    end
    nreset = 1'b1;
    step();
    checks++;
    if ({led, busy, done, cfg_ready} !== m_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h required %h",
               {led, busy, done, cfg_ready}, m_vec());
    end
  endtask

  task automatic test_blink();
    int rises[$];
    logic prev;
    wr(1, 2, 3, 0);
    checks++;
    if (cfg_ready !== 1'b0 || led[1] !== 1'b1 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL blink_accept: got rdy=%b led=%b busy=%b required 0 1 1",
               cfg_ready, led[1], busy[1]);
    end
    prev = led[1];
    for (int k = 0; k < 80; k++) begin
      checks++;
      if ({led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL blink k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      step();
      if (led[1] && !prev) rises.push_back(k);
      prev = led[1];
    end
    checks++;
    if (rises.size() < 2 || rises[$] - rises[$-1] != 24) begin
      errors++;
      $display("FAIL blink_period: got %0d rises last gap %0d required gap 24",
               rises.size(),
               rises.size() >= 2 ? rises[$] - rises[$-1] : -1);
    end
  endtask

  task automatic test_burst();
    int dn, rs;
    logic prev;
    dn = 0;
    rs = 0;
    wr(2, 3, 1, 2);
    prev = led[2];
    for (int k = 0; k < 40; k++) begin
      checks++;
      if ({led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL burst k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      if (done[2]) dn++;
      step();
      if (led[2] && !prev) rs++;
      prev = led[2];
    end
    checks++;
    if (dn != 1 || rs != 1 || led[2] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: got done=%0d rises=%0d led=%b busy=%b required 1 1 0 0",
               dn, rs, led[2], busy[2]);
    end
  endtask

  task automatic test_zero_burst_on();
    wr(0, 3, 5, 0);
    checks++;
    if (done[0] !== 1'b1 || led[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_burst: got done=%b led=%b busy=%b required 1 0 0",
               done[0], led[0], busy[0]);
    end
    step();
    checks++;
    if (done[0] !== 1'b0) begin
      errors++;
      $display("FAIL zero_burst_pulse: got done=%b required 0", done[0]);
    end
    wr(3, 1, 2, 0);
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (led[3] !== 1'b1 || busy[3] !== 1'b0 ||
          {led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL on_mode k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      step();
    end
  endtask

  task automatic test_tick_collision();
    int hi;
    for (int k = 0; k < 10 && !((m_cyc % P) == P - 1 && m_ready); k++)
      step();
    wr(1, 2, 3, 0);
    hi = 0;
    for (int k = 0; k < 30 && led[1] === 1'b1; k++) begin
      checks++;
      if ({led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL collide k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      hi++;
      step();
    end
    checks++;
    if (hi != 12) begin
      errors++;
      $display("FAIL collide_phase: got %0d cycles high required 12", hi);
    end
    wr(5, 1, 2, 2);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL bad_ch k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    wr(2, 3, 2, 3);
    for (int k = 0; k < 10; k++) step();
    nreset = 1'b0;
    step();
    checks++;
    if ({led, busy, done} !== '0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b required 0/1",
               {led, busy, done}, cfg_ready);
    end
    nreset = 1'b1;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== '0) dn++;
      step();
    end
    checks++;
    if (dn != 0 || busy !== '0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d pulses busy=%b required 0",
               dn, busy);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      checks++;
      if ({led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL random k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch = CHW'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_half = CW'($urandom_range(0, 3));
      cfg_count = CW'($urandom_range(0, 3));
      step();
    end
    cfg_valid = 1'b0;
  endtask

`ifdef MULTI_LED_SYNC_EN
  task automatic test_sync();
    wr(0, 2, 2, 0);
    for (int k = 0; k < 3; k++) step();
    wr(1, 2, 2, 0);
    for (int k = 0; k < 5; k++) step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (led[0] !== led[1] || {led, busy, done, cfg_ready} !== m_vec()) begin
        errors++;
        $display("FAIL sync k=%0d: got %h required %h",
                 k, {led, busy, done, cfg_ready}, m_vec());
      end
      step();
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_blink();
    test_burst();
    test_zero_burst_on();
    test_tick_collision();
    test_reset_mid();
    test_random();
`ifdef MULTI_LED_SYNC_EN
    test_sync();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
